bus_addr_decoder: RTL and testbench
===================================

Name: bus_addr_decoder

Overview:
- Single-master to NUM_SLAVES-slave address decoder and response router.
- Sits between the core data port and the memory-mapped peripherals: end-of-computation register, memories and accelerators.
- Decodes each request into one slave region and forwards the request to that slave.
- Tracks outstanding transactions in an in-order routing FIFO and steers each slave response back to the master.
- Unmapped addresses are answered locally with an error response.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUT, 2, routing FIFO depth = max outstanding transactions (power of two, >=1)
SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed per-slave base address
SLAVE_MASK, {NUM_SLAVES{32'h0}}, packed per-slave match mask

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  1  master request
m_we_i  in  1  master write enable
m_be_i  in  DATA_W/8  master byte enables
m_addr_i  in  ADDR_W  master address
m_wdata_i  in  DATA_W  master write data
m_gnt_o  out  1  grant to master
m_rvalid_o  out  1  response valid to master
m_rdata_o  out  DATA_W  response read data
m_err_o  out  1  response error
s_req_o  out  NUM_SLAVES  per-slave request
s_we_o  out  1  broadcast write enable
s_be_o  out  DATA_W/8  broadcast byte enables
s_addr_o  out  ADDR_W  broadcast address
s_wdata_o  out  DATA_W  broadcast write data
s_gnt_i  in  NUM_SLAVES  per-slave grant
s_rvalid_i  in  NUM_SLAVES  per-slave response valid
s_rdata_i  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
s_err_i  in  NUM_SLAVES  per-slave error
proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset is asynchronous, active-low on rst_ni; clock is clk_i.
- Reset values:
  - routing FIFO empty (count=0, pointers 0).
  - proto_err_o=0; error-pending flag=0.
  - All outputs 0 while no request is present and the FIFO is empty.
- Decode (combinational):
  - hit[i] = ((m_addr_i & SLAVE_MASK[i]) == SLAVE_BASE[i]).
  - Lowest index with hit wins; no hit = unmapped.
- Request path (combinational, zero latency):
  - s_we_o/s_be_o/s_addr_o/s_wdata_o always equal the master inputs.
  - s_req_o[sel] = m_req_i & !full; all other s_req_o bits 0.
  - m_gnt_o = s_req_o[sel] & s_gnt_i[sel] for a mapped access.
  - m_gnt_o = m_req_i & !full for an unmapped access; no slave request is issued.
  - full (count==MAX_OUT) blocks all requests. There is no same-cycle pop bypass.
- Push: on m_req_i & m_gnt_o, push {unmapped, sel} into the FIFO at the rising edge.
- Response path (strictly in order):
  - Head is a slave entry: m_rvalid_o = s_rvalid_i[head.sel], m_rdata_o = s_rdata_i[head.sel], m_err_o = s_err_i[head.sel]. Pop on m_rvalid_o. Zero added latency.
  - Head is an unmapped entry: registered error-pending flag asserts in the cycle after the entry reaches the head. That cycle drives m_rvalid_o=1, m_err_o=1, m_rdata_o=0, then pops.
  - An unmapped access granted at T with an empty FIFO responds at T+2.
  - FIFO empty: m_rvalid_o=0, m_rdata_o=0, m_err_o=0.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- Protocol checks:
  - Any s_rvalid_i[i] that is not the current head's slave sets proto_err_o; the response is dropped.
  - s_rvalid_i while the FIFO is empty sets proto_err_o.
  - proto_err_o clears only on reset.
- Pointer wrap: pointers are log2(MAX_OUT) bits and wrap modulo MAX_OUT; count is log2(MAX_OUT)+1 bits.
- Reset mid-transaction clears the FIFO immediately. Late slave responses after reset are flagged via proto_err_o.
- Single-cycle-response slaves (gnt=req, rvalid registered one cycle later) sustain one transaction per cycle when MAX_OUT>=2.

Test Plan:
- Regions: slave0 base 0x0000_0000 mask 0xFFFF_F000, slave1 base 0x1000_0000 mask 0xFFFF_FFF0. Read 0x1000_0000; slave1 gnt same cycle, rvalid next cycle with 0x1 -> s_req_o=4'b0010, m_gnt_o=1 at T, m_rvalid_o=1 m_rdata_o=0x1 m_err_o=0 at T+1.
- Write 0x1000_0000 wdata 0x1 -> only s_req_o[1] high, s_wdata_o=0x1, s_we_o=1, m_gnt_o=1 same cycle.
- Read unmapped 0x8000_0000 with FIFO empty -> m_gnt_o=1 at T, no s_req_o, m_rvalid_o=1 m_err_o=1 m_rdata_o=0 at T+2.
- Back-to-back: slave0 response held 3 cycles, then slave1 response -> third request blocked (m_gnt_o=0) while count=2; responses delivered in issue order; no extra rvalid.
- Overlapping regions (slave0 and slave1 both hit 0x1000_0000 when slave0 mask=0) -> slave0 selected.
- s_rvalid_i[2] asserted with FIFO empty -> proto_err_o=1 next cycle, stays 1 until rst_ni low; m_rvalid_o stays 0.

Source files
------------

// File: rtl/bus_addr_decoder.sv
// Single-master to NUM_SLAVES-slave address decoder and in-order response router.
// Requests are steered to the lowest-index matching region. Every granted request
// is remembered in a small routing FIFO so that responses can be matched to their
// slave. Unmapped addresses are answered locally with an error response.
module bus_addr_decoder #(
    parameter int unsigned                  NUM_SLAVES = 4,
    parameter int unsigned                  ADDR_W     = 32,
    parameter int unsigned                  DATA_W     = 32,
    parameter int unsigned                  MAX_OUT    = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         m_req_i,
    input  logic                         m_we_i,
    input  logic [DATA_W/8-1:0]          m_be_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    output logic                         m_gnt_o,
    output logic                         m_rvalid_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_err_o,
    output logic [NUM_SLAVES-1:0]        s_req_o,
    output logic                         s_we_o,
    output logic [DATA_W/8-1:0]          s_be_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    input  logic [NUM_SLAVES-1:0]        s_gnt_i,
    input  logic [NUM_SLAVES-1:0]        s_rvalid_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
    input  logic [NUM_SLAVES-1:0]        s_err_i,
    output logic                         proto_err_o
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;
    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] fifo_sel_q [MAX_OUT];
    logic [SEL_W-1:0] fifo_sel_d [MAX_OUT];
    logic             fifo_unm_q [MAX_OUT];
    logic             fifo_unm_d [MAX_OUT];
    logic             err_pend_q, err_pend_d;
    logic             proto_err_q, proto_err_d;

    logic             mapped;
    logic [SEL_W-1:0] sel;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [SEL_W-1:0] head_sel;
    logic             head_unm;
    logic             head_is_slave;

    assign full          = (count_q == CNT_W'(MAX_OUT));
    assign empty         = (count_q == '0);
    assign head_sel      = fifo_sel_q[rd_ptr_q];
    assign head_unm      = fifo_unm_q[rd_ptr_q];
    assign head_is_slave = !empty && !head_unm;

    assign s_we_o      = m_we_i;
    assign s_be_o      = m_be_i;
    assign s_addr_o    = m_addr_i;
    assign s_wdata_o   = m_wdata_i;
    assign proto_err_o = proto_err_q;

    // Address decode: lowest-index matching region wins
    always_comb begin
        mapped = 1'b0;
        sel    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                mapped = 1'b1;
                sel    = SEL_W'(i);
            end
        end
    end

    // Request forwarding and grant; a full FIFO blocks everything
    always_comb begin
        s_req_o = '0;
        m_gnt_o = 1'b0;
        if (mapped) begin
            s_req_o[sel] = m_req_i && !full;
            m_gnt_o      = m_req_i && !full && s_gnt_i[sel];
        end else begin
            m_gnt_o = m_req_i && !full;
        end
    end

    // Response steering from the FIFO head back to the master
    always_comb begin
        m_rvalid_o = 1'b0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        if (head_is_slave) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (head_sel == SEL_W'(i)) begin
                    m_rvalid_o = s_rvalid_i[i];
                    m_rdata_o  = s_rdata_i[i*DATA_W +: DATA_W];
                    m_err_o    = s_err_i[i];
                end
            end
        end else if (!empty && err_pend_q) begin
            m_rvalid_o = 1'b1;
            m_err_o    = 1'b1;
        end
    end

    assign push = m_req_i && m_gnt_o;
    assign pop  = m_rvalid_o;

    // Next-state for routing FIFO, error-pending flag and sticky protocol error
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_sel_d = fifo_sel_q;
        fifo_unm_d = fifo_unm_q;
        if (push) begin
            fifo_sel_d[wr_ptr_q] = sel;
            fifo_unm_d[wr_ptr_q] = !mapped;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        err_pend_d  = !empty && head_unm && !err_pend_q;
        proto_err_d = proto_err_q;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_rvalid_i[i] && !(head_is_slave && head_sel == SEL_W'(i))) begin
                proto_err_d = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_pend_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_sel_q[i] <= '0;
                fifo_unm_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_pend_q  <= err_pend_d;
            proto_err_q <= proto_err_d;
            fifo_sel_q  <= fifo_sel_d;
            fifo_unm_q  <= fifo_unm_d;
        end
    end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder: a table of combinational decode vectors
// followed by hand-written multi-cycle sequences for response ordering,
// unmapped errors, back-pressure, throughput, protocol errors and reset.
module tb_bus_addr_decoder;

    localparam logic [127:0] BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK = {32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_FFF0, 32'hFFFF_F000};
    localparam logic [127:0] OVL_MASK = {32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_FFF0, 32'h0000_0000};

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         m_req_i;
    logic         m_we_i;
    logic [3:0]   m_be_i;
    logic [31:0]  m_addr_i;
    logic [31:0]  m_wdata_i;
    logic         m_gnt_o;
    logic         m_rvalid_o;
    logic [31:0]  m_rdata_o;
    logic         m_err_o;
    logic [3:0]   s_req_o;
    logic         s_we_o;
    logic [3:0]   s_be_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_wdata_o;
    logic [3:0]   s_gnt_i;
    logic [3:0]   s_rvalid_i;
    logic [31:0]  rdata [4];
    logic [127:0] s_rdata_i;
    logic [3:0]   s_err_i;
    logic         proto_err_o;

    logic         o_gnt, o_rvalid, o_err, o_we, o_proto;
    logic [31:0]  o_rdata, o_addr, o_wdata;
    logic [3:0]   o_req, o_be;

    int n_cmp  = 0;
    int n_fail = 0;

    assign s_rdata_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

    always #5 clk_i = ~clk_i;

    bus_addr_decoder #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .MAX_OUT(2),
                       .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .m_err_o(m_err_o), .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .proto_err_o(proto_err_o)
    );

    bus_addr_decoder #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .MAX_OUT(2),
                       .SLAVE_BASE(BASE), .SLAVE_MASK(OVL_MASK)) dut_ovl (
        .clk_i(clk_i), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_gnt_o(o_gnt), .m_rvalid_o(o_rvalid), .m_rdata_o(o_rdata),
        .m_err_o(o_err), .s_req_o(o_req), .s_we_o(o_we), .s_be_o(o_be),
        .s_addr_o(o_addr), .s_wdata_o(o_wdata), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .proto_err_o(o_proto)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  exp_sreq;
        logic        exp_gnt;
    } vec_t;

    vec_t vecs [9];

    // Compare one observed value against its expected value
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one master request and slave handshake at a negative edge
    task automatic apply_stimulus(input logic req, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] gnt,
                                  input logic [3:0] rv);
        @(negedge clk_i);
        m_req_i    = req;
        m_we_i     = we;
        m_addr_i   = addr;
        m_wdata_i  = wdata;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        #1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        m_req_i    = 1'b0;
        m_we_i     = 1'b0;
        m_be_i     = 4'hF;
        m_addr_i   = '0;
        m_wdata_i  = '0;
        s_gnt_i    = '0;
        s_rvalid_i = '0;
        s_err_i    = '0;
        for (int i = 0; i < 4; i++) rdata[i] = 32'hDEAD_0000 + 32'(i);

        vecs[0] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'b0010, 4'b0010, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h1000_0004, 32'h1,         4'b0010, 4'b0010, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'b1111, 4'b0000, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 4'b0001, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_1000, 32'h5,         4'b0001, 4'b0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h2ABC_0000, 32'h0,         4'b0100, 4'b0100, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h4000_FFFF, 32'hCAFE_F00D, 4'b1111, 4'b1000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0,         4'b1111, 4'b0000, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         4'b0000, 4'b0000, 1'b1};

        // Reset state with idle inputs
        #12;
        check_output("reset m_gnt", 64'(m_gnt_o), 64'h0);
        check_output("reset m_rvalid", 64'(m_rvalid_o), 64'h0);
        check_output("reset m_rdata", 64'(m_rdata_o), 64'h0);
        check_output("reset s_req", 64'(s_req_o), 64'h0);
        check_output("reset proto_err", 64'(proto_err_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Combinational decode vectors; request withdrawn before each edge so nothing is pushed
        for (int v = 0; v < 9; v++) begin
            apply_stimulus(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].gnt, 4'b0000);
            check_output($sformatf("vec%0d s_req", v), 64'(s_req_o), 64'(vecs[v].exp_sreq));
            check_output($sformatf("vec%0d m_gnt", v), 64'(m_gnt_o), 64'(vecs[v].exp_gnt));
            check_output($sformatf("vec%0d s_addr", v), 64'(s_addr_o), 64'(vecs[v].addr));
            check_output($sformatf("vec%0d s_wdata", v), 64'(s_wdata_o), 64'(vecs[v].wdata));
            check_output($sformatf("vec%0d s_we", v), 64'(s_we_o), 64'(vecs[v].we));
            check_output($sformatf("vec%0d m_rvalid", v), 64'(m_rvalid_o), 64'h0);
            m_req_i = 1'b0;
        end

        // Overlapping regions: slave0 with mask 0 also matches 0x1000_0000 and wins
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b0011, 4'b0000);
        check_output("ovl s_req", 64'(o_req), 64'h1);
        check_output("ovl m_gnt", 64'(o_gnt), 64'h1);
        check_output("ovl main s_req", 64'(s_req_o), 64'h2);
        m_req_i = 1'b0;

        // Slave1 read: grant same cycle, response next cycle
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b0010, 4'b0000);
        check_output("rd1 s_req", 64'(s_req_o), 64'h2);
        check_output("rd1 m_gnt", 64'(m_gnt_o), 64'h1);
        rdata[1] = 32'h1;
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0010);
        check_output("rd1 m_rvalid", 64'(m_rvalid_o), 64'h1);
        check_output("rd1 m_rdata", 64'(m_rdata_o), 64'h1);
        check_output("rd1 m_err", 64'(m_err_o), 64'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("rd1 idle rvalid", 64'(m_rvalid_o), 64'h0);

        // Unmapped read answered locally two cycles after grant
        apply_stimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 4'b0000);
        check_output("unm m_gnt", 64'(m_gnt_o), 64'h1);
        check_output("unm s_req", 64'(s_req_o), 64'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("unm T+1 rvalid", 64'(m_rvalid_o), 64'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("unm T+2 rvalid", 64'(m_rvalid_o), 64'h1);
        check_output("unm T+2 err", 64'(m_err_o), 64'h1);
        check_output("unm T+2 rdata", 64'(m_rdata_o), 64'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("unm T+3 rvalid", 64'(m_rvalid_o), 64'h0);

        // Back-to-back with a slow slave0: FIFO fills, third request blocked, in-order delivery
        rdata[0] = 32'h0000_000A;
        rdata[1] = 32'h0000_000B;
        apply_stimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0001, 4'b0000);
        check_output("b2b c0 m_gnt", 64'(m_gnt_o), 64'h1);
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b0010, 4'b0000);
        check_output("b2b c1 m_gnt", 64'(m_gnt_o), 64'h1);
        for (int c = 2; c < 4; c++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0001, 4'b0000);
            check_output($sformatf("b2b c%0d m_gnt", c), 64'(m_gnt_o), 64'h0);
            check_output($sformatf("b2b c%0d s_req", c), 64'(s_req_o), 64'h0);
            check_output($sformatf("b2b c%0d rvalid", c), 64'(m_rvalid_o), 64'h0);
        end
        apply_stimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0001, 4'b0001);
        check_output("b2b c4 m_gnt", 64'(m_gnt_o), 64'h0);
        check_output("b2b c4 rvalid", 64'(m_rvalid_o), 64'h1);
        check_output("b2b c4 rdata", 64'(m_rdata_o), 64'hA);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0010);
        check_output("b2b c5 rvalid", 64'(m_rvalid_o), 64'h1);
        check_output("b2b c5 rdata", 64'(m_rdata_o), 64'hB);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("b2b c6 rvalid", 64'(m_rvalid_o), 64'h0);
        check_output("b2b c6 proto_err", 64'(proto_err_o), 64'h0);

        // Single-cycle slave sustains one transaction per cycle (push and pop together)
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b0010, 4'b0000);
        check_output("thr c0 m_gnt", 64'(m_gnt_o), 64'h1);
        rdata[1] = 32'h11;
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b0010, 4'b0010);
        check_output("thr c1 m_gnt", 64'(m_gnt_o), 64'h1);
        check_output("thr c1 rdata", 64'(m_rdata_o), 64'h11);
        rdata[1] = 32'h22;
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0010);
        check_output("thr c2 rvalid", 64'(m_rvalid_o), 64'h1);
        check_output("thr c2 rdata", 64'(m_rdata_o), 64'h22);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("thr c3 rvalid", 64'(m_rvalid_o), 64'h0);
        check_output("thr c3 proto_err", 64'(proto_err_o), 64'h0);

        // Stray response with empty FIFO: sticky protocol error, nothing forwarded
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0100);
        check_output("proto rvalid", 64'(m_rvalid_o), 64'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("proto set", 64'(proto_err_o), 64'h1);
        repeat (3) @(negedge clk_i);
        check_output("proto sticky", 64'(proto_err_o), 64'h1);
        rst_ni = 1'b0;
        #1;
        check_output("proto cleared", 64'(proto_err_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset with a transaction outstanding: the late response is a protocol error
        apply_stimulus(1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'b0010, 4'b0000);
        check_output("mid m_gnt", 64'(m_gnt_o), 64'h1);
        @(negedge clk_i);
        m_req_i = 1'b0;
        s_gnt_i = '0;
        rst_ni  = 1'b0;
        #2;
        rst_ni  = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0010);
        check_output("mid late rvalid", 64'(m_rvalid_o), 64'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
        check_output("mid late proto", 64'(proto_err_o), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
